// File: rtl/load_store_unit.sv
// RV32I memory-stage LSU: 2+ stall cycles per access (accept + BUSY until mem_ready), stalls the pipeline while memory withholds mem_ready.
// Optional MISALIGN_TRAP_EN: misaligned H/HU/W accesses skip the bus, pulse MisalignM and return zero.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  AddressingControlM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
`ifdef MISALIGN_TRAP_EN
    output logic        MisalignM,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] counter;
    logic [2:0]  ctrl_q;
    logic [1:0]  lo_q;

    logic        is_byte;
    logic        is_half;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        trap;

    assign is_byte = (AddressingControlM[1:0] == 2'b00);
    assign is_half = (AddressingControlM[1:0] == 2'b01);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        if (is_byte) begin
            be_next    = 4'b0001 << ALUResultM[1:0];
            wdata_next = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            be_next    = 4'b0011 << {ALUResultM[1], 1'b0};
            wdata_next = {2{WriteDataM[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_half && ALUResultM[0]) ||
                        (!is_byte && !is_half && (ALUResultM[1:0] != 2'b00));
    assign trap      = misaligned;
    assign MisalignM = !rst && (state == IDLE) && MemReqM && misaligned;
`else
    assign trap = 1'b0;
`endif

    // Lane selection uses the address bits latched at accept time, not the live ALU result.
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    assign byte_lane = 8'(mem_rdata >> {lo_q, 3'b000});
    assign half_lane = 16'(mem_rdata >> {lo_q[1], 4'b0000});

    always_comb begin
        load_ext = mem_rdata;
        case (ctrl_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_ext = {24'b0, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_ext = {16'b0, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    assign StallM = !rst && (((state == IDLE) && MemReqM) || (state == BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= 16'd0;
            ctrl_q    <= 3'b000;
            lo_q      <= 2'b00;
            ReadDataM <= 32'b0;
            BusErrM   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 32'b0;
            mem_be    <= 4'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemReqM) begin
                        ctrl_q    <= AddressingControlM;
                        lo_q      <= ALUResultM[1:0];
                        mem_addr  <= {ALUResultM[31:2], 2'b00};
                        mem_wdata <= MemWriteM ? wdata_next : 32'b0;
                        mem_be    <= MemWriteM ? be_next : 4'b0;
                        counter   <= 16'd0;
                        if (trap) begin
                            mem_we    <= 1'b0;
                            ReadDataM <= 32'b0;
                            state     <= DONE;
                        end else begin
                            mem_we  <= MemWriteM;
                            mem_req <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            ReadDataM <= load_ext;
                        end
                        mem_req <= 1'b0;
                        counter <= 16'd0;
                        state   <= DONE;
                    end else if (counter == LAST_CYCLE) begin
                        // Abandon the access; a late mem_ready is never looked at outside BUSY.
                        mem_req   <= 1'b0;
                        BusErrM   <= 1'b1;
                        ReadDataM <= 32'b0;
                        counter   <= 16'd0;
                        state     <= DONE;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against a behavioural model.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [2:0]  AddressingControlM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] ReadDataM, mem_addr, mem_wdata;
    logic        StallM, BusErrM, mem_req, mem_we, MisalignM;
    logic [3:0]  mem_be;
    logic [31:0] l_rd, l_addr, l_wdata;
    logic        l_stall, l_err, l_req, l_we, l_mis;
    logic [3:0]  l_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .AddressingControlM(AddressingControlM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM),
`ifdef MISALIGN_TRAP_EN
        .MisalignM(MisalignM),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Default-timeout instance, used for the long-latency load scenario only.
    load_store_unit dut_long (
        .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .AddressingControlM(AddressingControlM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(l_rd), .StallM(l_stall), .BusErrM(l_err),
`ifdef MISALIGN_TRAP_EN
        .MisalignM(l_mis),
`endif
        .mem_req(l_req), .mem_we(l_we), .mem_addr(l_addr), .mem_wdata(l_wdata),
        .mem_be(l_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

`ifndef MISALIGN_TRAP_EN
    assign MisalignM = 1'b0;
    assign l_mis     = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    bit          exp_on = 1'b0;
    bit          exp_stall, exp_req, exp_err, exp_mis, chk_bus, exp_we;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] cur_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] model_be(input logic [2:0] c, input logic [1:0] a);
        case (c)
            3'b000, 3'b100: begin
                case (a)
                    2'd0:    return 4'b0001;
                    2'd1:    return 4'b0010;
                    2'd2:    return 4'b0100;
                    default: return 4'b1000;
                endcase
            end
            3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] wd);
        case (c)
            3'b000, 3'b100: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            3'b001, 3'b101: return {wd[15:0], wd[15:0]};
            default:        return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        idx = int'(a);
        b = w[idx*8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (c)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] c, input logic [1:0] a);
        if (c == 3'b000 || c == 3'b100) return 1'b0;
        if (c == 3'b001 || c == 3'b101) return a[0];
        return a != 2'b00;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_on) begin
            check("StallM", 32'(StallM), 32'(exp_stall));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("BusErrM", 32'(BusErrM), 32'(exp_err));
            check("ReadDataM", ReadDataM, exp_rd);
`ifdef MISALIGN_TRAP_EN
            check("MisalignM", 32'(MisalignM), 32'(exp_mis));
`endif
            if (chk_bus) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_be", 32'(mem_be), 32'(exp_be));
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        MemReqM            = 1'($urandom);
        MemWriteM          = 1'($urandom);
        AddressingControlM = 3'($urandom);
        ALUResultM         = $urandom;
        WriteDataM         = $urandom;
    endtask

    task automatic idle(input bit rdy);
        next_cycle();
        MemReqM   = 1'b0;
        MemWriteM = 1'($urandom);
        mem_ready = rdy;
        mem_rdata = $urandom;
        exp_on = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        chk_bus = 1'b0; exp_rd = cur_rd;
        @(negedge clk);
    endtask

    // delay = BUSY cycle (1-based) in which mem_ready is returned; 0 or > TMO means never.
    task automatic do_access(input bit we, input logic [2:0] ctl, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int delay,
                             output int stalls);
        bit timed_out;
        bit trap;
        int k;
        timed_out = 1'b0;
        trap      = 1'b0;
        k         = 0;
`ifdef MISALIGN_TRAP_EN
        trap = model_misaligned(ctl, addr[1:0]);
`endif
        stalls = 0;
        next_cycle();
        MemReqM = 1'b1; MemWriteM = we; AddressingControlM = ctl; ALUResultM = addr; WriteDataM = wd;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        exp_on = 1'b1; exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_mis = trap;
        chk_bus = 1'b0; exp_rd = cur_rd;
        @(negedge clk);
        stalls += int'(StallM);
        exp_addr  = {addr[31:2], 2'b00};
        exp_we    = we;
        exp_be    = we ? model_be(ctl, addr[1:0]) : 4'b0000;
        exp_wdata = model_wdata(ctl, wd);
        if (!trap) begin
            do begin
                k++;
                next_cycle();
                scramble_inputs();
                mem_ready = (k == delay);
                mem_rdata = (k == delay) ? rd : $urandom;
                exp_stall = 1'b1; exp_req = 1'b1; exp_mis = 1'b0; chk_bus = 1'b1;
                @(negedge clk);
                stalls += int'(StallM);
            end while (k != delay && k < TMO);
            timed_out = (k != delay);
        end
        next_cycle();
        scramble_inputs();
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = timed_out; exp_mis = 1'b0; chk_bus = 1'b0;
        if (trap || timed_out) cur_rd = 32'h0;
        else if (!we)          cur_rd = model_load(ctl, addr[1:0], rd);
        exp_rd = cur_rd;
        @(negedge clk);
    endtask

    initial begin
        int          st;
        int          lst;
        bit          r_we;
        bit          r_trap;
        logic [2:0]  r_c;
        logic [31:0] r_a, r_wd, r_rd;
        int          r_d;

        rst = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; AddressingControlM = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        cur_rd = 32'h0;
        #1 rst = 1'b1;
        #2;
        check("rst_ReadDataM", ReadDataM, 32'h0);
        check("rst_StallM", 32'(StallM), 32'h0);
        check("rst_BusErrM", 32'(BusErrM), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_long_out", {l_rd | l_addr | l_wdata, 28'(0), l_be} == 60'h0 ? 32'h0 : 32'h1, 32'h0);
        check("rst_long_ctl", 32'({l_stall, l_err, l_req, l_we, l_mis, MisalignM}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // model pins
        check("pin_lb", model_load(3'b000, 2'b11, 32'h80FF_1234), 32'hFFFF_FF80);
        check("pin_sh_be", 32'(model_be(3'b001, 2'b10)), 32'hC);
        check("pin_sh_wd", model_wdata(3'b001, 32'h0000_BEEF), 32'hBEEF_BEEF);
        check("pin_lhu", model_load(3'b101, 2'b00, 32'h0000_F00D), 32'h0000_F00D);

        // LHU, ready after 5 BUSY cycles, on the default-timeout instance
        lst = 0;
        next_cycle();
        MemReqM = 1'b1; MemWriteM = 1'b0; AddressingControlM = 3'b101; ALUResultM = 32'h0; mem_ready = 1'b0;
        @(negedge clk);
        lst += int'(l_stall);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            MemReqM = 1'b0;
            mem_ready = (k == 5);
            mem_rdata = (k == 5) ? 32'h0000_F00D : $urandom;
            @(negedge clk);
            lst += int'(l_stall);
            if (k == 1) check("lhu_req", 32'({l_req, l_we, l_be}), 32'h20);
        end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        lst += int'(l_stall);
        check("lhu_stall_cycles", 32'(lst), 32'd6);
        check("lhu_rdata", l_rd, 32'h0000_F00D);
        check("lhu_buserr", 32'(l_err), 32'h0);
        cur_rd = 32'h0;
        idle(1'b0);

        do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, st);
        check("lb_stall_cycles", 32'(st), 32'd2);
        check("lb_rdata", ReadDataM, 32'hFFFF_FF80);

        do_access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, $urandom, 2, st);
        check("sh_rdata_kept", ReadDataM, 32'hFFFF_FF80);

        do_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, $urandom, 0, st);
        check("tmo_stall_cycles", 32'(st), 32'(1 + TMO));
        check("tmo_rdata", ReadDataM, 32'h0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // reset in the middle of a BUSY access
        next_cycle();
        MemReqM = 1'b1; MemWriteM = 1'b0; AddressingControlM = 3'b010; ALUResultM = 32'h40; mem_ready = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0; chk_bus = 1'b0; exp_rd = cur_rd;
        @(negedge clk);
        next_cycle();
        MemReqM = 1'b0;
        exp_req = 1'b1; chk_bus = 1'b1; exp_addr = 32'h40; exp_we = 1'b0; exp_be = 4'b0;
        @(negedge clk);
        next_cycle();
        exp_on = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_busy_req", 32'(mem_req), 32'h0);
        check("rst_busy_stall", 32'(StallM), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cur_rd = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0; chk_bus = 1'b0; exp_rd = 32'h0;
        exp_on = 1'b1;
        @(negedge clk);
        do_access(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, st);
        check("lw_after_rst", ReadDataM, 32'hDEAD_BEEF);
        check("lw_stall_cycles", 32'(st), 32'd3);

`ifdef MISALIGN_TRAP_EN
        do_access(1'b0, 3'b010, 32'h0000_0006, 32'h0, $urandom, 1, st);
        check("mis_stall_cycles", 32'(st), 32'd1);
        check("mis_rdata", ReadDataM, 32'h0);
`endif

        for (int i = 0; i < 80; i++) begin
            r_we = 1'($urandom);
            r_c  = 3'($urandom);
            r_a  = $urandom;
            r_wd = $urandom;
            r_rd = $urandom;
            r_d  = $urandom_range(0, TMO + 1);
            r_trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_trap = model_misaligned(r_c, r_a[1:0]);
`endif
            do_access(r_we, r_c, r_a, r_wd, r_rd, r_d, st);
            check("rand_stall_cycles", 32'(st),
                  r_trap ? 32'd1 : 32'(1 + ((r_d >= 1 && r_d <= TMO) ? r_d : TMO)));
            repeat ($urandom_range(0, 2)) idle(1'($urandom));
        end

        exp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
